writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage of the MISC-V 16-bit core, directly downstream of the memory stage.
//  - Owns the MEM/WB pipeline register.
//  - Selects the write-back value from ALU result, load data or PC+2.
//  - Drives the register-file write port.
//  - Provides a WB->EX forwarding path and a saturating retired-instruction counter.
// PARAMETERS
//  DATA_W      16  datapath width
//  RA_W        3   register address width; r0 (addr 0) is hard-wired zero
//  CNT_W       16  retired-instruction counter width
// PORTS
//  clk         in   1       core clock; all state on rising edge
//  reset       in   1       asynchronous, active-low reset
//  IRegWrite   in   1       MEM: instruction writes a register
//  IRegStore   in   1       MEM: 1 = write-back source is load data
//  ILink       in   1       MEM: 1 = write-back source is PC+2 (overrides IRegStore)
//  IValid      in   1       MEM: slot holds a real instruction (0 = bubble)
//  IPCP2       in   DATA_W  MEM: PC+2 of instruction
//  IALUResult  in   DATA_W  MEM: ALU result / address
//  IRd         in   RA_W    MEM: destination register
//  LoadData    in   DATA_W  synchronous data-memory q; valid in the WB cycle of a load
//  Stall       in   1       hold MEM/WB contents this cycle
//  Flush       in   1       replace incoming slot with a bubble
//  RfWe        out  1       register-file write enable
//  RfAddr      out  RA_W    register-file write address
//  RfData      out  DATA_W  register-file write data
//  FwdValid    out  1       forwarding entry live (== RfWe)
//  FwdRd       out  RA_W    forwarding destination (== RfAddr)
//  FwdData     out  DATA_W  forwarding value (== RfData)
//  RetireCnt   out  CNT_W   saturating count of retired instructions
// BEHAVIOUR
//  Reset (reset==0, async):
//   - MEM/WB regs clear: valid=0, RegWrite=0, rd=0, data=0.
//   - Load-hold register clears; hold flag clears.
//   - RetireCnt=0; hence RfWe=0, RfAddr=0, RfData=0.
//   - Reset mid-operation discards the in-flight slot; no write occurs.
//  MEM/WB register, per rising edge:
//   - Flush=1: load bubble (valid=0, RegWrite=0). Flush has priority over Stall.
//   - else Stall=1: hold all fields.
//   - else capture I* inputs.
//   - Latency: MEM inputs appear at RfWe/RfAddr/RfData one cycle after capture edge.
//  Write-back select (combinational from MEM/WB regs):
//   - ILink=1 -> PC+2; else IRegStore=1 -> load data; else ALU result.
//   - Load data = hold ? LoadHold : LoadData.
//  Load hold:
//   - First cycle of a stall with a held load slot: LoadHold <= LoadData and hold <= 1.
//   - hold clears on the first non-stalled edge.
//   - Guarantees the loaded value is stable across multi-cycle stalls, even if the memory q changes.
//  Write enable: RfWe = valid & RegWrite & (rd != 0) & ~Stall.
//   - A stalled slot writes exactly once: on the cycle Stall drops, not repeatedly.
//   - Writes to r0 are suppressed; forwarding of r0 is likewise suppressed.
//  Retire counter:
//   - Increments on every edge where a valid slot leaves WB (valid & ~Stall), including non-writing instructions.
//   - Saturates at all-ones; no wrap.
//  Stall and Flush asserted together: Flush wins; the held slot is discarded and never writes.
// STRUCTURE
//  - misc_v_pkg: WB source encodings (WB_ALU, WB_MEM, WB_PC), DATA_W/RA_W defaults, REG_ZERO constant.
//  - Sub-module mem_wb_reg: MEM/WB pipeline register with Stall/Flush and async active-low reset.
//  - Top level contains the write-back mux, load-hold logic, write-enable gating and retire counter.
// TESTING
//  1. Reset: assert reset=0 mid-stream with a valid ALU op in MEM -> RfWe=0, RetireCnt=0 immediately (async).
//  2. ALU op: IALUResult=16'h1234, IRd=3, IRegWrite=1 -> next cycle RfWe=1, RfAddr=3, RfData=1234, RetireCnt+1.
//  3. Load with 3-cycle stall: LoadData=16'hBEEF in first WB cycle, then changed to 16'h0000 during the stall
//     -> RfData=BEEF when Stall drops; single RfWe pulse.
//  4. Link: ILink=1, IPCP2=16'h0042, IRegStore=1 -> RfData=0042 (link wins).
//  5. r0 / flush: IRd=0 write -> RfWe=0 but RetireCnt+1; Flush=1 with Stall=1 -> bubble, no write, no count.
//  6. Counter saturation: preload near max (CNT_W=4 build), retire 20 instrs -> RetireCnt stays 4'hF.

Source files
------------

// File: rtl/misc_v_pkg.sv
// Shared definitions for the MISC-V 16-bit core: datapath defaults and
// write-back source encodings.
package misc_v_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_RA_W   = 3;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wbSrc_e;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB handshake bundle: incoming MEM slot, memory q, pipeline control,
// and the register-file / forwarding outputs of the write-back stage.
interface writeback_stage_if
  import misc_v_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RA_W   = DEF_RA_W
);

  logic              IRegWrite;
  logic              IRegStore;
  logic              ILink;
  logic              IValid;
  logic [DATA_W-1:0] IPCP2;
  logic [DATA_W-1:0] IALUResult;
  logic [RA_W-1:0]   IRd;
  logic [DATA_W-1:0] LoadData;
  logic              Stall;
  logic              Flush;

  logic              RfWe;
  logic [RA_W-1:0]   RfAddr;
  logic [DATA_W-1:0] RfData;
  logic              FwdValid;
  logic [RA_W-1:0]   FwdRd;
  logic [DATA_W-1:0] FwdData;

  modport master (
    output IRegWrite, IRegStore, ILink, IValid, IPCP2, IALUResult, IRd,
    output LoadData, Stall, Flush,
    input  RfWe, RfAddr, RfData, FwdValid, FwdRd, FwdData
  );

  modport slave (
    input  IRegWrite, IRegStore, ILink, IValid, IPCP2, IALUResult, IRd,
    input  LoadData, Stall, Flush,
    output RfWe, RfAddr, RfData, FwdValid, FwdRd, FwdData
  );

endinterface

// File: rtl/writeback_stage_mem_wb_reg.sv
// MEM/WB pipeline register. Flush loads a bubble and beats Stall; Stall holds
// every field.
module mem_wb_reg
  import misc_v_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RA_W   = DEF_RA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              memValid,
  input  logic              memRegWrite,
  input  wbSrc_e            memSrc,
  input  logic [RA_W-1:0]   memRd,
  input  logic [DATA_W-1:0] memData,
  output logic              wbValid,
  output logic              wbRegWrite,
  output wbSrc_e            wbSrc,
  output logic [RA_W-1:0]   wbRd,
  output logic [DATA_W-1:0] wbData
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbValid    <= 1'b0;
      wbRegWrite <= 1'b0;
      wbSrc      <= WB_ALU;
      wbRd       <= '0;
      wbData     <= '0;
    end else if (flush) begin
      wbValid    <= 1'b0;
      wbRegWrite <= 1'b0;
      wbSrc      <= WB_ALU;
      wbRd       <= '0;
      wbData     <= '0;
    end else if (!stall) begin
      wbValid    <= memValid;
      wbRegWrite <= memRegWrite;
      wbSrc      <= memSrc;
      wbRd       <= memRd;
      wbData     <= memData;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB register, result select, load-hold across stalls,
// register-file write gating, forwarding and saturating retire counter.
module writeback_stage
  import misc_v_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RA_W   = DEF_RA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  writeback_stage_if.slave   wb,
  output logic [CNT_W-1:0]   RetireCnt
);

  wbSrc_e            memSrc;
  logic [DATA_W-1:0] memData;
  logic              wbValid;
  logic              wbRegWrite;
  wbSrc_e            wbSrc;
  logic [RA_W-1:0]   wbRd;
  logic [DATA_W-1:0] wbData;
  logic              holdValid;
  logic [DATA_W-1:0] loadHold;
  logic [DATA_W-1:0] loadValue;
  logic [DATA_W-1:0] wbValue;
  logic              slotLoad;
  logic              slotLeaves;
  logic              writeEn;

  // PC+2 and ALU result share one data field; load data arrives a cycle later.
  always_comb begin
    memSrc = WB_ALU;
    if (wb.ILink) begin
      memSrc = WB_PC;
    end else if (wb.IRegStore) begin
      memSrc = WB_MEM;
    end
  end

  assign memData = wb.ILink ? wb.IPCP2 : wb.IALUResult;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W)
  ) u_mem_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .stall       (wb.Stall),
    .flush       (wb.Flush),
    .memValid    (wb.IValid),
    .memRegWrite (wb.IRegWrite),
    .memSrc      (memSrc),
    .memRd       (wb.IRd),
    .memData     (memData),
    .wbValid     (wbValid),
    .wbRegWrite  (wbRegWrite),
    .wbSrc       (wbSrc),
    .wbRd        (wbRd),
    .wbData      (wbData)
  );

  assign slotLoad   = wbValid & (wbSrc == WB_MEM);
  assign slotLeaves = wbValid & ~wb.Stall;

  // Memory q is only valid in the first WB cycle; latch it when a stall begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdValid <= 1'b0;
      loadHold  <= '0;
    end else if (wb.Flush || !wb.Stall) begin
      holdValid <= 1'b0;
    end else if (!holdValid && slotLoad) begin
      holdValid <= 1'b1;
      loadHold  <= wb.LoadData;
    end
  end

  assign loadValue = holdValid ? loadHold : wb.LoadData;

  always_comb begin
    wbValue = wbData;
    case (wbSrc)
      WB_MEM:  wbValue = loadValue;
      default: wbValue = wbData;
    endcase
  end

  assign writeEn = wbValid & wbRegWrite & (wbRd != RA_W'(REG_ZERO)) & ~wb.Stall;

  assign wb.RfWe     = writeEn;
  assign wb.RfAddr   = wbRd;
  assign wb.RfData   = wbValue;
  assign wb.FwdValid = writeEn;
  assign wb.FwdRd    = wbRd;
  assign wb.FwdData  = wbValue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RetireCnt <= '0;
    end else if (slotLeaves && !(&RetireCnt)) begin
      RetireCnt <= RetireCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a slot-level model predicts every cycle,
// hand-computed checks pin the key scenarios; a CNT_W=4 copy shows saturation.
module tb_writeback_stage;
  import misc_v_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  writeback_stage_if #(.DATA_W(16), .RA_W(3)) wbA ();
  writeback_stage_if #(.DATA_W(16), .RA_W(3)) wbB ();

  assign wbB.IRegWrite  = wbA.IRegWrite;
  assign wbB.IRegStore  = wbA.IRegStore;
  assign wbB.ILink      = wbA.ILink;
  assign wbB.IValid     = wbA.IValid;
  assign wbB.IPCP2      = wbA.IPCP2;
  assign wbB.IALUResult = wbA.IALUResult;
  assign wbB.IRd        = wbA.IRd;
  assign wbB.LoadData   = wbA.LoadData;
  assign wbB.Stall      = wbA.Stall;
  assign wbB.Flush      = wbA.Flush;

  writeback_stage #(.DATA_W(16), .RA_W(3), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (wbA),
    .RetireCnt (cnt16)
  );

  writeback_stage #(.DATA_W(16), .RA_W(3), .CNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .wb        (wbB),
    .RetireCnt (cnt4)
  );

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the instruction currently sitting in WB and the number retired.
  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        isLoad;
    logic        isLink;
    logic        loadSeen;
    logic [2:0]  rd;
    logic [15:0] alu;
    logic [15:0] pc;
    logic [15:0] loadVal;
  } slot_t;

  slot_t       wbSlot;
  int unsigned retired;
  logic        expWe;
  logic [15:0] expData;

  function automatic logic [31:0] sat(input int unsigned n, input int unsigned maxVal);
    return (n > maxVal) ? maxVal : n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbSlot  = '0;
      retired = 0;
    end else begin
      if (wbSlot.valid && !wbA.Stall) retired++;
      if (wbA.Flush) begin
        wbSlot = '0;
      end else if (!wbA.Stall) begin
        wbSlot          = '0;
        wbSlot.valid    = wbA.IValid;
        wbSlot.regWrite = wbA.IRegWrite;
        wbSlot.isLink   = wbA.ILink;
        wbSlot.isLoad   = wbA.IRegStore & ~wbA.ILink;
        wbSlot.rd       = wbA.IRd;
        wbSlot.alu      = wbA.IALUResult;
        wbSlot.pc       = wbA.IPCP2;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_rst_we",   32'(wbA.RfWe), 32'd0);
      chk("m_rst_addr", 32'(wbA.RfAddr), 32'd0);
      chk("m_rst_data", 32'(wbA.RfData), 32'd0);
      chk("m_rst_cnt",  32'(cnt16), 32'd0);
      chk("m_rst_cnt4", 32'(cnt4), 32'd0);
    end else begin
      // A load's value is whatever memory presents in its first WB cycle.
      if (!wbSlot.loadSeen) begin
        wbSlot.loadSeen = 1'b1;
        wbSlot.loadVal  = wbA.LoadData;
      end
      expWe   = wbSlot.valid & wbSlot.regWrite & (wbSlot.rd != 3'd0) & ~wbA.Stall;
      expData = wbSlot.isLink ? wbSlot.pc : (wbSlot.isLoad ? wbSlot.loadVal : wbSlot.alu);
      chk("m_we",       32'(wbA.RfWe), 32'(expWe));
      chk("m_fwdvalid", 32'(wbA.FwdValid), 32'(expWe));
      chk("m_cnt16",    32'(cnt16), sat(retired, 32'hFFFF));
      chk("m_cnt4",     32'(cnt4), sat(retired, 32'hF));
      if (expWe) begin
        chk("m_addr",    32'(wbA.RfAddr), 32'(wbSlot.rd));
        chk("m_data",    32'(wbA.RfData), 32'(expData));
        chk("m_fwdrd",   32'(wbA.FwdRd), 32'(wbSlot.rd));
        chk("m_fwddata", 32'(wbA.FwdData), 32'(expData));
      end
    end
  end

  task automatic setIn(input logic v, input logic rw, input logic rs, input logic lk,
                       input logic [15:0] pc, input logic [15:0] alu, input logic [2:0] rd,
                       input logic [15:0] ld, input logic st, input logic fl);
    wbA.IValid     = v;
    wbA.IRegWrite  = rw;
    wbA.IRegStore  = rs;
    wbA.ILink      = lk;
    wbA.IPCP2      = pc;
    wbA.IALUResult = alu;
    wbA.IRd        = rd;
    wbA.LoadData   = ld;
    wbA.Stall      = st;
    wbA.Flush      = fl;
  endtask

  task automatic bubble(input logic [15:0] ld, input logic st, input logic fl);
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, ld, st, fl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bubble(16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",   32'(wbA.RfWe), 32'd0);
    chk("rst_addr", 32'(wbA.RfAddr), 32'd0);
    chk("rst_data", 32'(wbA.RfData), 32'd0);
    chk("rst_cnt",  32'(cnt16), 32'd0);
    reset = 1'b1;
    tick();

    // ALU op
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h1234, 3'd3, 16'h0, 1'b0, 1'b0);
    tick();
    bubble(16'h0, 1'b0, 1'b0);
    #1;
    chk("alu_we",   32'(wbA.RfWe), 32'd1);
    chk("alu_addr", 32'(wbA.RfAddr), 32'd3);
    chk("alu_data", 32'(wbA.RfData), 32'h1234);
    chk("alu_fwd",  32'(wbA.FwdData), 32'h1234);
    tick();
    chk("alu_cnt",  32'(cnt16), 32'd1);

    // Load held across a 3-cycle stall while memory q changes
    setIn(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0100, 3'd5, 16'h0, 1'b0, 1'b0);
    tick();
    bubble(16'hBEEF, 1'b1, 1'b0);
    #1;
    chk("ld_stall_we", 32'(wbA.RfWe), 32'd0);
    tick();
    bubble(16'h0000, 1'b1, 1'b0);
    tick();
    tick();
    bubble(16'h0000, 1'b0, 1'b0);
    #1;
    chk("ld_we",   32'(wbA.RfWe), 32'd1);
    chk("ld_data", 32'(wbA.RfData), 32'hBEEF);
    tick();
    chk("ld_once_we", 32'(wbA.RfWe), 32'd0);
    chk("ld_cnt",     32'(cnt16), 32'd2);

    // Link overrides load select
    setIn(1'b1, 1'b1, 1'b1, 1'b1, 16'h0042, 16'hFFFF, 3'd7, 16'hDEAD, 1'b0, 1'b0);
    tick();
    bubble(16'hDEAD, 1'b0, 1'b0);
    #1;
    chk("lk_we",   32'(wbA.RfWe), 32'd1);
    chk("lk_data", 32'(wbA.RfData), 32'h0042);
    tick();

    // r0 write suppressed but retired
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h5555, 3'd0, 16'h0, 1'b0, 1'b0);
    tick();
    bubble(16'h0, 1'b0, 1'b0);
    #1;
    chk("r0_we",  32'(wbA.RfWe), 32'd0);
    chk("r0_fwd", 32'(wbA.FwdValid), 32'd0);
    tick();
    chk("r0_cnt", 32'(cnt16), 32'd4);

    // Flush together with Stall discards the held slot
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h2222, 3'd2, 16'h0, 1'b0, 1'b0);
    tick();
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'hAAAA, 3'd4, 16'h0, 1'b1, 1'b1);
    #1;
    chk("fs_we", 32'(wbA.RfWe), 32'd0);
    tick();
    bubble(16'h0, 1'b0, 1'b0);
    #1;
    chk("fs_we2", 32'(wbA.RfWe), 32'd0);
    tick();
    chk("fs_cnt", 32'(cnt16), 32'd4);

    // Flush alone: WB slot still writes, incoming slot becomes a bubble
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h1111, 3'd1, 16'h0, 1'b0, 1'b0);
    tick();
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h6666, 3'd6, 16'h0, 1'b0, 1'b1);
    #1;
    chk("fl_we",   32'(wbA.RfWe), 32'd1);
    chk("fl_data", 32'(wbA.RfData), 32'h1111);
    tick();
    bubble(16'h0, 1'b0, 1'b0);
    #1;
    chk("fl_bub_we", 32'(wbA.RfWe), 32'd0);
    tick();
    chk("fl_cnt", 32'(cnt16), 32'd5);

    // 20 back-to-back retirements: 4-bit counter pins at F
    for (int i = 0; i < 20; i++) begin
      setIn(1'b1, 1'b1, (i % 3) == 0, 1'b0, 16'(i * 2), 16'(i * 16'h0111), 3'(i),
            16'(16'hC000 + i), 1'b0, 1'b0);
      tick();
    end
    bubble(16'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("sat_cnt16", 32'(cnt16), 32'd25);
    chk("sat_cnt4",  32'(cnt4), 32'hF);

    // Asynchronous reset with a live slot in WB
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h7777, 3'd3, 16'h0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_we", 32'(wbA.RfWe), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_we",   32'(wbA.RfWe), 32'd0);
    chk("arst_cnt",  32'(cnt16), 32'd0);
    chk("arst_cnt4", 32'(cnt4), 32'd0);
    bubble(16'h0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_cnt", 32'(cnt16), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
